ka_seq_gf2_mul: RTL and testbench

Parametrised, resource-shared Karatsuba multiplier for binary polynomials over GF(2) (carry-less, XOR-accumulate). It computes the three half-width sub-products (lo·lo, hi·hi, mid·mid) one per cycle on a single combinational half-width multiplier, then recombines them with the Karatsuba overlap. It replaces fixed-width, fully combinational Karatsuba stages where area matters more than throughput, for example as the leaf of the large-field multiplier tree. It connects through a valid/ready handshake on both sides.

---
 rtl/ka_pkg.sv | 16 +
 rtl/gf2_mul_comb.sv | 17 +
 rtl/ka_seq_gf2_mul.sv | 130 +++++++++++++
 tb/tb_ka_seq_gf2_mul.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ka_pkg.sv
// Shared types and helpers for the sequential Karatsuba GF(2) multiplier.
package ka_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      MUL_LO  = 3'd1,
      MUL_HI  = 3'd2,
      MUL_MID = 3'd3,
      DONE    = 3'd4
   } ka_state_t;

   function automatic int half_w(input int n);
      return (n + 1) / 2;
   endfunction

endpackage

// File: rtl/gf2_mul_comb.sv
// Purely combinational W x W carry-less multiplier (XOR of AND partial products).
module gf2_mul_comb #(
   parameter int W = 7
) (
   input  logic [W-1:0]   x,
   input  logic [W-1:0]   z,
   output logic [2*W-2:0] p
);

   always_comb begin
      p = '0;
      for (int i = 0; i < W; i++) begin
         if (z[i]) p = p ^ ((2*W-1)'(x) << i);
      end
   end

endmodule

// File: rtl/ka_seq_gf2_mul.sv
// Resource-shared Karatsuba GF(2) multiplier: three half-width sub-products on one
// combinational multiplier, one per cycle, then the Karatsuba overlap recombination.
module ka_seq_gf2_mul
   import ka_pkg::*;
#(
   parameter int N = 13
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-2:0] y
);

   localparam int H  = half_w(N);
   localparam int PW = 2*H - 1;
   localparam int YW = 2*N - 1;

   ka_state_t      state_q, state_d;
   logic [N-1:0]   a_q, a_d, b_q, b_d;
   logic [PW-1:0]  p_lo_q, p_lo_d, p_hi_q, p_hi_d;
   logic [YW-1:0]  y_q, y_d;
   logic           ov_q, ov_d;

   logic [H-1:0]   a_lo, a_hi, b_lo, b_hi;
   logic [H-1:0]   mx, mz;
   logic [PW-1:0]  p_mul;
   logic [YW-1:0]  y_rec;

   // High half is zero-extended when N is odd.
   assign a_lo = a_q[H-1:0];
   assign b_lo = b_q[H-1:0];
   assign a_hi = H'(a_q[N-1:H]);
   assign b_hi = H'(b_q[N-1:H]);

   always_comb begin
      mx = a_lo;
      mz = b_lo;
      case (state_q)
         MUL_HI: begin
            mx = a_hi;
            mz = b_hi;
         end
         MUL_MID: begin
            mx = a_lo ^ a_hi;
            mz = b_lo ^ b_hi;
         end
         default: ;
      endcase
   end

   gf2_mul_comb #(.W(H)) u_mul (
      .x (mx),
      .z (mz),
      .p (p_mul)
   );

   // Valid only in MUL_MID, where p_mul carries p_mid; upper product bits are zero.
   assign y_rec = YW'(p_lo_q)
                ^ (YW'(p_lo_q ^ p_hi_q ^ p_mul) << H)
                ^ (YW'(p_hi_q) << (2*H));

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      p_lo_d  = p_lo_q;
      p_hi_d  = p_hi_q;
      y_d     = y_q;
      ov_d    = ov_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               state_d = MUL_LO;
            end
         end
         MUL_LO: begin
            p_lo_d  = p_mul;
            state_d = MUL_HI;
         end
         MUL_HI: begin
            p_hi_d  = p_mul;
            state_d = MUL_MID;
         end
         MUL_MID: begin
            y_d     = y_rec;
            ov_d    = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) begin
               ov_d    = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         p_lo_q  <= '0;
         p_hi_q  <= '0;
         y_q     <= '0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         p_lo_q  <= p_lo_d;
         p_hi_q  <= p_hi_d;
         y_q     <= y_d;
         ov_q    <= ov_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = ov_q;
   assign y         = y_q;

endmodule

// File: tb/tb_ka_seq_gf2_mul.sv
// Self-checking bench: directed N=13 scenarios plus parallel random regressions.
module tb_ka_seq_gf2_mul;
   import ka_pkg::*;

   localparam int NPROD   = 10000;
   localparam int CYC_MAX = 80000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Bit-serial carry-less reference.
   function automatic logic [127:0] clmul(input logic [63:0] x, input logic [63:0] z, input int n);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < n; i++) begin
         if (z[i]) r = r ^ ({64'd0, x} << i);
      end
      return r;
   endfunction

   // Untruncated Karatsuba recombination, used to assert the upper bits are zero.
   function automatic logic [127:0] kara_full(input logic [63:0] x, input logic [63:0] z, input int n);
      int h;
      logic [63:0] hm;
      logic [127:0] pl, ph, pm;
      h  = (n + 1) / 2;
      hm = (64'd1 << h) - 64'd1;
      pl = clmul(x & hm, z & hm, h);
      ph = clmul(x >> h, z >> h, h);
      pm = clmul((x & hm) ^ (x >> h), (z & hm) ^ (z >> h), h);
      return pl ^ ((pl ^ ph ^ pm) << h) ^ (ph << (2*h));
   endfunction

   // ---------------- directed DUT, N = 13 ----------------
   logic        d_rst, d_iv, d_ir, d_ov, d_or;
   logic [12:0] d_a, d_b;
   logic [24:0] d_y;
   logic [127:0] d_q[$];

   ka_seq_gf2_mul #(.N(13)) u_dut (
      .clk       (clk),
      .rst       (d_rst),
      .in_valid  (d_iv),
      .in_ready  (d_ir),
      .a         (d_a),
      .b         (d_b),
      .out_valid (d_ov),
      .out_ready (d_or),
      .y         (d_y)
   );

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic d_run(input logic [12:0] ta, input logic [12:0] tb_op,
                        input logic [24:0] ex, input int hold, input string tag);
      int cnt;
      cnt = 0;
      d_q.push_back(128'(ex));
      d_iv = 1'b1;
      d_a  = ta;
      d_b  = tb_op;
      step();
      d_iv = 1'b0;
      d_a  = 13'($urandom);
      d_b  = 13'($urandom);
      while (!d_ov && cnt < 10) begin
         chk({tag, "_busy_rdy"}, d_ir, 0);
         step();
         cnt++;
      end
      chk({tag, "_lat"}, cnt, 3);
      chk({tag, "_done_rdy"}, d_ir, 0);
      repeat (hold) begin
         step();
         chk({tag, "_hold_v"}, d_ov, 1);
         chk({tag, "_hold_y"}, d_y, (d_q.size() != 0) ? d_q[0] : 128'd0);
      end
      chk({tag, "_sb"}, d_q.size(), 1);
      if (d_q.size() != 0) chk({tag, "_y"}, d_y, d_q.pop_front());
      d_or = 1'b1;
      step();
      d_or = 1'b0;
      chk({tag, "_ov_clr"}, d_ov, 0);
      chk({tag, "_idle"}, d_ir, 1);
   endtask

   // ---------------- random regressions ----------------
   localparam int NS [5] = '{2, 7, 13, 16, 33};

   for (genvar gi = 0; gi < 5; gi++) begin : g_rnd
      localparam int NN = NS[gi];
      logic            r_rst, r_iv, r_ir, r_ov, r_or;
      logic [NN-1:0]   r_a, r_b;
      logic [2*NN-2:0] r_y;
      logic            done = 1'b0;
      logic [127:0]    q[$];

      ka_seq_gf2_mul #(.N(NN)) u_dut (
         .clk       (clk),
         .rst       (r_rst),
         .in_valid  (r_iv),
         .in_ready  (r_ir),
         .a         (r_a),
         .b         (r_b),
         .out_valid (r_ov),
         .out_ready (r_or),
         .y         (r_y)
      );

      initial begin
         logic [63:0]  ra, rb, m;
         logic [127:0] full, rf;
         int pushed, cyc;
         pushed = 0;
         cyc    = 0;
         m      = (64'd1 << NN) - 64'd1;
         r_rst  = 1'b1;
         r_iv   = 1'b0;
         r_or   = 1'b0;
         r_a    = '0;
         r_b    = '0;
         repeat (2) @(negedge clk);
         r_rst = 1'b0;
         while ((pushed < NPROD || q.size() != 0) && cyc < CYC_MAX) begin
            @(negedge clk);
            cyc++;
            ra = {$urandom, $urandom} & m;
            rb = {$urandom, $urandom} & m;
            if ($urandom_range(0, 15) == 0) ra = m;
            if ($urandom_range(0, 15) == 0) rb = m;
            r_a  = ra[NN-1:0];
            r_b  = rb[NN-1:0];
            r_iv = (pushed < NPROD) && ($urandom_range(0, 15) != 0);
            r_or = ($urandom_range(0, 7) != 0);
            if (r_iv && r_ir) begin
               rf   = clmul(ra, rb, NN);
               full = kara_full(ra, rb, NN);
               chk($sformatf("rnd%0d_upper0", NN), full >> (2*NN-1), '0);
               chk($sformatf("rnd%0d_kara", NN), full, rf);
               q.push_back(rf);
               pushed++;
            end
            if (r_ov && r_or) begin
               chk($sformatf("rnd%0d_sb", NN), q.size() != 0, 1);
               if (q.size() != 0) chk($sformatf("rnd%0d_y", NN), 128'(r_y), q.pop_front());
            end
         end
         chk($sformatf("rnd%0d_drain", NN), q.size(), 0);
         chk($sformatf("rnd%0d_count", NN), pushed, NPROD);
         r_iv = 1'b0;
         r_or = 1'b0;
         done = 1'b1;
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      d_rst = 1'b1;
      d_iv  = 1'b0;
      d_or  = 1'b0;
      d_a   = '0;
      d_b   = '0;
      repeat (2) step();
      d_rst = 1'b0;
      chk("rst_ov", d_ov, 0);
      chk("rst_y", d_y, 0);
      chk("rst_rdy", d_ir, 1);

      d_run(13'h0003, 13'h0003, 25'h0000005, 1, "sq3");
      d_run(13'h1FFF, 13'h1FFF, 25'h1555555, 0, "sq_ones");
      d_run(13'h1000, 13'h1000, 25'h1000000, 0, "sq_top");
      d_run(13'h1001, 13'h0003, 25'h0003003, 6, "hold6");

      // Operand change and a second request while busy must not be captured.
      d_q.push_back(clmul(64'h0ABC, 64'h1234, 13));
      d_iv = 1'b1;
      d_a  = 13'h0ABC;
      d_b  = 13'h1234;
      step();
      d_iv = 1'b0;
      step();
      d_iv = 1'b1;
      d_a  = 13'h1FFF;
      d_b  = 13'h0777;
      chk("busy_rdy_hi", d_ir, 0);
      step();
      d_iv = 1'b0;
      step();
      chk("busy_ov", d_ov, 1);
      chk("busy_sb", d_q.size(), 1);
      if (d_q.size() != 0) chk("busy_y", d_y, d_q.pop_front());
      d_or = 1'b1;
      step();
      d_or = 1'b0;
      repeat (6) step();
      chk("busy_no_second", d_ov, 0);
      chk("busy_idle", d_ir, 1);

      // Reset during MUL_MID aborts the product.
      d_iv = 1'b1;
      d_a  = 13'h1FFF;
      d_b  = 13'h1FFF;
      step();
      d_iv = 1'b0;
      step();
      step();
      d_rst = 1'b1;
      step();
      d_rst = 1'b0;
      chk("abort_ov", d_ov, 0);
      chk("abort_y", d_y, 0);
      chk("abort_rdy", d_ir, 1);
      repeat (4) step();
      chk("abort_quiet", d_ov, 0);
      d_run(13'h0001, 13'h0001, 25'h0000001, 0, "after_rst");

      wait (g_rnd[0].done && g_rnd[1].done && g_rnd[2].done && g_rnd[3].done && g_rnd[4].done);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #(1500000);
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
